// File: rtl/offchip_mem_ctrl_pkg.sv
// rtl/offchip_mem_ctrl_pkg.sv - shared line-size config and controller state encodings
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 32
`endif

package offchip_mem_ctrl_pkg;

  localparam int CACHE_LINE_SIZE_C = `CACHE_LINE_SIZE;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_BEAT = 2'd1;
  localparam logic [1:0] ST_WR_BEAT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RD_BEAT = ST_RD_BEAT,
    WR_BEAT = ST_WR_BEAT,
    DONE    = ST_DONE
  } state_e;

  // Mask that clears the byte-offset bits of a line address.
  function automatic logic [31:0] line_mask(input int off_bits);
    return ~((32'd1 << off_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/offchip_mem_ctrl.sv
// rtl/offchip_mem_ctrl.sv - cache-line to 32-bit external word burst controller
module offchip_mem_ctrl
  import offchip_mem_ctrl_pkg::*;
#(
  parameter int LINE_BYTES = CACHE_LINE_SIZE_C,
  parameter int BEATS      = LINE_BYTES / 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             offchip_mem_addr,
  input  logic                    offchip_mem_read_en,
  input  logic                    offchip_mem_write_en,
  input  logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
  output logic [LINE_BYTES*8-1:0] offchip_mem_data,
  output logic                    offchip_mem_ready,
  output logic                    offchip_mem_read_busy,
  output logic                    offchip_mem_write_busy,
  output logic [31:0]             ext_addr,
  output logic                    ext_req,
  output logic                    ext_we,
  output logic [31:0]             ext_wdata,
  input  logic [31:0]             ext_rdata,
  input  logic                    ext_ack
);

  localparam int              BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int              LW        = LINE_BYTES * 8;
  localparam logic [31:0]     BASE_MASK = line_mask($clog2(LINE_BYTES));
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q;
  logic [31:0]   base_q;
  logic [LW-1:0] wline_q;
  logic [LW-1:0] rline_q;
  logic          is_wr_q;
  logic          beat_active;
  logic          accept;
  logic          accept_wr;

  assign beat_active = (state_q == RD_BEAT) || (state_q == WR_BEAT);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    accept_wr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (offchip_mem_write_en) begin
          state_d   = WR_BEAT;
          accept    = 1'b1;
          accept_wr = 1'b1;
        end else if (offchip_mem_read_en) begin
          state_d = RD_BEAT;
          accept  = 1'b1;
        end
      end
      RD_BEAT, WR_BEAT: begin
        if (ext_ack && (beat_q == LAST_BEAT)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request inputs are sampled only on acceptance; afterwards the latched copies drive the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q  <= '0;
      base_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      is_wr_q <= 1'b0;
    end else if (accept) begin
      beat_q  <= '0;
      base_q  <= offchip_mem_addr & BASE_MASK;
      is_wr_q <= accept_wr;
      if (accept_wr) wline_q <= offchip_mem_wdata;
    end else if (beat_active && ext_ack) begin
      beat_q <= beat_q + 1'b1;
      if (state_q == RD_BEAT) rline_q[32*beat_q +: 32] <= ext_rdata;
    end
  end

  assign ext_req   = beat_active;
  assign ext_we    = (state_q == WR_BEAT);
  assign ext_addr  = beat_active ? (base_q + (32'(beat_q) << 2)) : 32'd0;
  assign ext_wdata = (state_q == WR_BEAT) ? wline_q[32*beat_q +: 32] : 32'd0;

  assign offchip_mem_data       = rline_q;
  assign offchip_mem_ready      = (state_q == DONE);
  assign offchip_mem_read_busy  = (state_q == RD_BEAT) || ((state_q == DONE) && !is_wr_q);
  assign offchip_mem_write_busy = (state_q == WR_BEAT) || ((state_q == DONE) && is_wr_q);

endmodule

// File: doc/offchip_mem_ctrl.md
OFFCHIP_MEM_CTRL -- requirements
Module: offchip_mem_ctrl

Interface
REQ-001 Parameter: LINE_BYTES, default `CACHE_LINE_SIZE`, cache line size in bytes; a multiple of 4, at least 8.
REQ-002 Parameter: BEATS, default LINE_BYTES/4, 32-bit words per line.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 offchip_mem_addr  input  32  line request address from the cache.
REQ-006 offchip_mem_read_en  input  1  level line-read request.
REQ-007 offchip_mem_write_en  input  1  level line-write request.
REQ-008 offchip_mem_wdata  input  LINE_BYTES*8  line to write.
REQ-009 offchip_mem_data  output  LINE_BYTES*8  line read result.
REQ-010 offchip_mem_ready  output  1  one-cycle completion pulse.
REQ-011 offchip_mem_read_busy  output  1  a line read is in progress.
REQ-012 offchip_mem_write_busy  output  1  a line write is in progress.
REQ-013 ext_addr  output  32  word address toward external memory.
REQ-014 ext_req  output  1  external word access request.
REQ-015 ext_we  output  1  external access is a write.
REQ-016 ext_wdata  output  32  external write word.
REQ-017 ext_rdata  input  32  external read word, valid with ext_ack.
REQ-018 ext_ack  input  1  external beat-complete strobe.

Function
REQ-019 The FSM SHALL have the states IDLE, RD_BEAT, WR_BEAT and DONE.
REQ-020 In IDLE, write_en=1 SHALL go to WR_BEAT; otherwise read_en=1 SHALL go to RD_BEAT; when both are high, the write wins and the still-high read is accepted after DONE.
REQ-021 On acceptance the block SHALL latch the base address as addr with bits [log2(LINE_BYTES)-1:0] cleared, latch wdata for writes, and clear the beat counter.
REQ-022 The enables, addr and wdata SHALL be ignored outside IDLE.
REQ-023 In RD_BEAT and WR_BEAT: ext_req=1, ext_addr=base+4*beat, and ext_we=1 only in WR_BEAT.
REQ-024 In WR_BEAT, ext_wdata SHALL equal line bits [32*beat+31:32*beat] (little-endian word order).
REQ-025 On ext_req&ext_ack in RD_BEAT, ext_rdata SHALL be stored into line bits [32*beat+31:32*beat].
REQ-026 On ext_req&ext_ack the beat counter SHALL increment, and the FSM SHALL go to DONE when beat=BEATS-1.
REQ-027 ext_req, ext_addr, ext_we and ext_wdata SHALL hold stable until ext_ack; ext_ack while ext_req=0 SHALL be ignored.
REQ-028 DONE SHALL last exactly one cycle with offchip_mem_ready=1, then return to IDLE.
REQ-029 offchip_mem_data SHALL be valid in DONE of a read and hold until the next read beat overwrites it.
REQ-030 read_busy SHALL be 1 in RD_BEAT and in DONE of a read; write_busy SHALL be 1 in WR_BEAT and in DONE of a write; the two SHALL never be 1 together.
REQ-031 With ext_ack tied high, latency SHALL be: accept at cycle t, beats at t+1..t+BEATS, ready at t+BEATS+1.
REQ-032 An initiator that still holds an enable in the DONE cycle SHALL get a new transaction accepted on the following IDLE cycle.

Reset
REQ-033 rst SHALL force IDLE, clear the beat counter, and drive every output to 0, including data and ext_addr.
REQ-034 rst mid-transaction SHALL abort without a ready pulse; external memory contents are undefined after a write aborted this way.

Structure
REQ-035 LINE_BYTES SHALL come from the shared config include; the state encodings SHALL be localparams in that shared include.
REQ-036 There SHALL be no sub-module: the FSM, beat counter and line buffer live in this module.

Verification
REQ-037 With LINE_BYTES=32, ack tied high, read_en at addr 0x1000_0014 and ext_rdata=ext_addr, the bench SHALL see ext_addr 0x1000_0000..0x1000_001C, data word i = 0x1000_0000+4i, and ready at t+9.
REQ-038 A write of 0x..07060504_03020100 at 0x2000_0000 SHALL produce 8 ext_we beats with ext_wdata word0=0x03020100, then ready; write_busy SHALL be high for cycles t+1..t+9.
REQ-039 With ack delayed 3 cycles per beat, ext outputs SHALL stay stable while waiting, and ready SHALL come at t+1+8*4.
REQ-040 With read_en and write_en both high, the bench SHALL see the write complete, then the read accepted in the cycle after DONE, with a separate ready pulse for each.
REQ-041 rst asserted at beat 3 of a read SHALL clear all outputs immediately, with no ready; a new read after reset SHALL start at beat 0.
REQ-042 Toggling read_en mid-read and ack without req SHALL have no effect on the beat count or the data.
